// File: rtl/xpb_lut_bank.sv
// Run-time loadable multi-channel XPB lookup bank: streamed table load, parallel registered lookups.
// Optional XPB_LUT_OUTREG_EN adds a second output register stage (latency 2).
module xpb_lut_bank #(
    parameter int unsigned WORD_W = 1024,
    parameter int unsigned IDX_W  = 5,
    parameter int unsigned NUM_CH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       i_load_start,
    input  logic                       i_ld_valid,
    output logic                       o_ld_ready,
    input  logic [WORD_W-1:0]          i_ld_data,
    output logic                       o_table_ready,
    input  logic [NUM_CH-1:0]          i_lkp_valid,
    input  logic [NUM_CH*IDX_W-1:0]    i_lkp_idx,
    output logic [NUM_CH-1:0]          o_out_valid,
    output logic [NUM_CH*WORD_W-1:0]   o_out_data,
    output logic                       o_lkp_err
);

    localparam int unsigned DEPTH = 2 ** IDX_W;

    localparam logic [1:0] S_EMPTY = 2'd0;
    localparam logic [1:0] S_LOAD  = 2'd1;
    localparam logic [1:0] S_READY = 2'd2;

    localparam logic [IDX_W-1:0] PTR_FIRST = IDX_W'(1);
    localparam logic [IDX_W-1:0] PTR_LAST  = IDX_W'(DEPTH - 1);

    logic [1:0]               r_state;
    logic [IDX_W-1:0]         r_ld_ptr;
    logic                     r_lkp_err;
    logic [WORD_W-1:0]        r_mem [DEPTH];
    logic [NUM_CH-1:0]        r_out_valid;
    logic [NUM_CH*WORD_W-1:0] r_out_data;

    logic                     w_accept;
    logic                     w_table_ready;
    logic [NUM_CH-1:0]        w_hit;
    logic [WORD_W-1:0]        w_rd [NUM_CH];

    assign w_table_ready = (r_state == S_READY);
    assign o_ld_ready    = (r_state == S_LOAD) & ~i_load_start;
    assign w_accept      = i_ld_valid & o_ld_ready;
    assign w_hit         = i_lkp_valid & {NUM_CH{w_table_ready}};
    assign o_table_ready = w_table_ready;
    assign o_lkp_err     = r_lkp_err;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_EMPTY;
            r_ld_ptr  <= PTR_FIRST;
            r_lkp_err <= 1'b0;
        end else if (i_load_start) begin
            r_state   <= S_LOAD;
            r_ld_ptr  <= PTR_FIRST;
            r_lkp_err <= 1'b0;
        end else begin
            if (w_accept) begin
                if (r_ld_ptr == PTR_LAST) begin
                    r_state  <= S_READY;
                    r_ld_ptr <= PTR_FIRST;
                end else begin
                    r_ld_ptr <= r_ld_ptr + PTR_FIRST;
                end
            end
            if (|i_lkp_valid && !w_table_ready) begin
                r_lkp_err <= 1'b1;
            end
        end
    end

    // Storage is deliberately unreset; validity is tracked by the FSM alone.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_mem[r_ld_ptr] <= i_ld_data;
        end
    end

    always_comb begin
        for (int c = 0; c < NUM_CH; c++) begin
            w_rd[c] = '0;
            if (i_lkp_idx[c*IDX_W +: IDX_W] != '0) begin
                w_rd[c] = r_mem[i_lkp_idx[c*IDX_W +: IDX_W]];
            end
        end
    end

    // Data holds its last value on idle cycles; only reset clears it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= '0;
            r_out_data  <= '0;
        end else begin
            r_out_valid <= w_hit;
            for (int c = 0; c < NUM_CH; c++) begin
                if (w_hit[c]) begin
                    r_out_data[c*WORD_W +: WORD_W] <= w_rd[c];
                end
            end
        end
    end

`ifdef XPB_LUT_OUTREG_EN
    logic [NUM_CH-1:0]        r_out2_valid;
    logic [NUM_CH*WORD_W-1:0] r_out2_data;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out2_valid <= '0;
            r_out2_data  <= '0;
        end else begin
            r_out2_valid <= r_out_valid;
            r_out2_data  <= r_out_data;
        end
    end

    assign o_out_valid = r_out2_valid;
    assign o_out_data  = r_out2_data;
`else
    assign o_out_valid = r_out_valid;
    assign o_out_data  = r_out_data;
`endif

endmodule

// File: tb/tb_xpb_lut_bank.sv
// Randomised bench for xpb_lut_bank against a table/pipeline model kept in the bench.
module tb_xpb_lut_bank;
    localparam int W  = 1024;
    localparam int IW = 5;
    localparam int NC = 4;
    localparam int D  = 32;
`ifdef XPB_LUT_OUTREG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             load_start = 1'b0;
    logic             ld_valid = 1'b0;
    logic             ld_ready;
    logic [W-1:0]     ld_data = '0;
    logic             table_ready;
    logic [NC-1:0]    lkp_valid = '0;
    logic [NC*IW-1:0] lkp_idx = '0;
    logic [NC-1:0]    out_valid;
    logic [NC*W-1:0]  out_data;
    logic             lkp_err;

    xpb_lut_bank #(.WORD_W(W), .IDX_W(IW), .NUM_CH(NC)) dut (
        .clk(clk), .rst_n(rst_n),
        .i_load_start(load_start), .i_ld_valid(ld_valid), .o_ld_ready(ld_ready),
        .i_ld_data(ld_data), .o_table_ready(table_ready),
        .i_lkp_valid(lkp_valid), .i_lkp_idx(lkp_idx),
        .o_out_valid(out_valid), .o_out_data(out_data), .o_lkp_err(lkp_err)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    int n_beats = 0;

    // Model: table contents, load progress, and an LAT-deep result pipe.
    logic [W-1:0]  m_mem [D];
    bit            m_loading, m_ready, m_err;
    int            m_ptr;
    logic [NC-1:0] p_v [LAT];
    logic [W-1:0]  p_d [LAT][NC];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chk_w(input string name, input int ch, input logic [W-1:0] act,
                         input logic [W-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s ch%0d: got low64 %h expected low64 %h (t=%0t)", name, ch,
                     act[63:0], exp[63:0], $time);
        end
    endtask

    function automatic logic [W-1:0] pat(input int k, input logic [31:0] x);
        logic [W-1:0] w;
        logic [31:0] v;
        v = 32'(k) ^ x;
        for (int i = 0; i < W / 32; i++) w[i*32 +: 32] = v;
        return w;
    endfunction

    task automatic rand_word(output logic [W-1:0] w);
        for (int i = 0; i < W / 32; i++) w[i*32 +: 32] = $urandom;
    endtask

    task automatic model_reset();
        m_loading = 0; m_ready = 0; m_err = 0; m_ptr = 1;
        for (int s = 0; s < LAT; s++) begin
            p_v[s] = '0;
            for (int c = 0; c < NC; c++) p_d[s][c] = '0;
        end
    endtask

    task automatic compare_outputs();
        chk("table_ready", 64'(table_ready), 64'(m_ready));
        chk("lkp_err", 64'(lkp_err), 64'(m_err));
        chk("out_valid", 64'(out_valid), 64'(p_v[LAT-1]));
        for (int c = 0; c < NC; c++) chk_w("out_data", c, out_data[c*W +: W], p_d[LAT-1][c]);
    endtask

    // One clock: check ld_ready, advance model with current inputs, compare after the edge.
    task automatic step();
        logic [NC-1:0] nv;
        logic [W-1:0]  nd [NC];
        int            ix;
        #1;
        chk("ld_ready", 64'(ld_ready), 64'(m_loading && !load_start));
        for (int c = 0; c < NC; c++) begin
            ix = int'(lkp_idx[c*IW +: IW]);
            if (lkp_valid[c] && m_ready) begin
                nv[c] = 1'b1;
                nd[c] = (ix == 0) ? '0 : m_mem[ix];
            end else begin
                nv[c] = 1'b0;
                nd[c] = p_d[0][c];
            end
        end
        if (load_start) begin
            m_loading = 1; m_ready = 0; m_err = 0; m_ptr = 1;
        end else begin
            if (lkp_valid != '0 && !m_ready) m_err = 1;
            if (m_loading && ld_valid) begin
                n_beats++;
                m_mem[m_ptr] = ld_data;
                if (m_ptr == D - 1) begin
                    m_loading = 0; m_ready = 1; m_ptr = 1;
                end else begin
                    m_ptr++;
                end
            end
        end
        @(posedge clk);
        for (int s = LAT - 1; s > 0; s--) begin
            p_v[s] = p_v[s-1];
            for (int c = 0; c < NC; c++) p_d[s][c] = p_d[s-1][c];
        end
        p_v[0] = nv;
        for (int c = 0; c < NC; c++) p_d[0][c] = nd[c];
        #1;
        compare_outputs();
    endtask

    task automatic idle_inputs();
        load_start = 0; ld_valid = 0; lkp_valid = '0;
    endtask

    // Reset asserted for one cycle; outputs must clear asynchronously.
    task automatic pulse_reset();
        rst_n = 0;
        idle_inputs();
        model_reset();
        #1;
        chk("rst_ld_ready", 64'(ld_ready), 64'd0);
        compare_outputs();
        @(posedge clk);
        #1;
        rst_n = 1;
    endtask

    task automatic do_load(input logic [31:0] x, input int nbeats);
        load_start = 1; step(); load_start = 0;
        for (int k = 1; k <= nbeats; k++) begin
            ld_valid = 1; ld_data = pat(k, x); step();
        end
        ld_valid = 0;
    endtask

    initial begin
        model_reset();
        #2;
        pulse_reset();

        // Back-to-back load of {32{k}}.
        n_beats = 0;
        do_load(32'h0, 31);
        chk("t1_beats", 64'(n_beats), 64'd31);
        chk("t1_table_ready", 64'(table_ready), 64'd1);
        #1;
        chk("t1_ld_ready_low", 64'(ld_ready), 64'd0);

        // Four channels in one cycle: idx 0, 1, 17, 31.
        lkp_valid = 4'hF;
        lkp_idx = {5'd31, 5'd17, 5'd1, 5'd0};
        step();
        lkp_valid = '0;
        for (int i = 1; i < LAT; i++) step();
        chk("t2_valid", 64'(out_valid), 64'hF);
        chk_w("t2_data", 0, out_data[0 +: W], '0);
        chk_w("t2_data", 1, out_data[W +: W], {32{32'd1}});
        chk_w("t2_data", 2, out_data[2*W +: W], {32{32'd17}});
        chk_w("t2_data", 3, out_data[3*W +: W], {32{32'd31}});
        step();
        chk("t2_valid_drop", 64'(out_valid), 64'h0);
        chk_w("t2_hold", 3, out_data[3*W +: W], {32{32'd31}});

        // Lookup before any load is dropped and flags a sticky error.
        pulse_reset();
        lkp_valid = 4'b0010;
        lkp_idx = '0;
        lkp_idx[IW +: IW] = 5'd5;
        step();
        lkp_valid = '0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("t3_valid", 64'(out_valid), 64'h0);
            chk("t3_err_held", 64'(lkp_err), 64'd1);
        end

        // load_start clears the error; restart at beat 10 then full reload of a new pattern.
        do_load(32'h0, 9);
        chk("t3_err_clear", 64'(lkp_err), 64'd0);
        load_start = 1; ld_valid = 1; ld_data = pat(10, 32'h0); step();
        chk("t4_not_ready", 64'(table_ready), 64'd0);
        load_start = 0; ld_valid = 0;
        for (int k = 1; k <= 31; k++) begin
            ld_valid = 1; ld_data = pat(k, 32'hA5A5_0000); step();
        end
        ld_valid = 0;
        lkp_valid = 4'b0001;
        lkp_idx = '0;
        lkp_idx[0 +: IW] = 5'd10;
        step();
        lkp_valid = '0;
        for (int i = 1; i < LAT; i++) step();
        chk_w("t4_new_val", 0, out_data[0 +: W], {32{32'hA5A5_000A}});
        for (int i = 0; i < D; i++) begin
            lkp_valid = 4'hF;
            for (int c = 0; c < NC; c++) lkp_idx[c*IW +: IW] = IW'((i + c * 8) % D);
            step();
        end
        lkp_valid = '0;

        // Random load gaps, restarts and lookups.
        load_start = 1; step(); load_start = 0;
        for (int n = 0; n < 2000; n++) begin
            load_start = ($urandom_range(0, 399) == 0);
            ld_valid = 1'($urandom_range(0, 1));
            rand_word(ld_data);
            lkp_valid = NC'($urandom);
            lkp_idx = (NC*IW)'($urandom);
            step();
        end
        idle_inputs();
        for (int i = 0; i < LAT; i++) step();

        // Reset mid-load at beat 20.
        do_load(32'h5A00_0000, 20);
        pulse_reset();
        chk("t6_table_ready", 64'(table_ready), 64'd0);
        lkp_valid = 4'b0100;
        step();
        lkp_valid = '0;
        chk("t6_err", 64'(lkp_err), 64'd1);
        for (int i = 0; i < LAT; i++) step();
        chk("t6_valid", 64'(out_valid), 64'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: bench did not complete");
        $fatal(1);
    end
endmodule
